// File: rtl/data_path.sv
// ---------------------------------------------------------------------------
// data_path -- datapath half of the K&S multicycle processor.
//
// Holds the program counter, instruction register, a 4x16 register file,
// the 16-bit ALU and the registered status flags. The control unit drives the
// strobes and selects; this block returns the decoded instruction and flags.
// Instructions and data share one memory, so ram_addr is either the PC
// (fetch) or the address field of the current instruction (LOAD/STORE).
//
// Ports:
//   clk, rst             clock (rising edge) and asynchronous active-high reset
//   branch               PC load source: 1 = IR[4:0], 0 = PC+1
//   pc_enable            PC update strobe
//   ir_enable            IR <= data_in
//   write_reg_enable     register file write strobe
//   addr_sel             ram_addr source: 1 = IR[4:0], 0 = PC
//   c_sel                register write data: 1 = ALU result, 0 = data_in
//   operation            ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
//   flags_reg_enable     flags register load strobe
//   decoded_instruction  combinational decode of IR
//   zero_op, neg_op, unsigned_overflow, signed_overflow   registered flags
//   ram_addr, data_out, data_in                           unified memory bus
//
// Optional feature: define KS_R0_ZERO_EN to hardwire R0 to zero.
// ---------------------------------------------------------------------------

package k_and_s_pkg;
   typedef enum logic [4:0] {
      I_NOP, I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNZERO, I_BNNEG, I_BNOV,
      I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_HALT
   } decoded_instruction_type;
endpackage

module data_path
   import k_and_s_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 5,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    branch,
   input  logic                    pc_enable,
   input  logic                    ir_enable,
   input  logic                    write_reg_enable,
   input  logic                    addr_sel,
   input  logic                    c_sel,
   input  logic [1:0]              operation,
   input  logic                    flags_reg_enable,
   output decoded_instruction_type decoded_instruction,
   output logic                    zero_op,
   output logic                    neg_op,
   output logic                    unsigned_overflow,
   output logic                    signed_overflow,
   output logic [ADDR_WIDTH-1:0]   ram_addr,
   output logic [15:0]             data_out,
   input  logic [15:0]             data_in
);

   logic [ADDR_WIDTH-1:0] pc;
   logic [15:0]           ir;
   logic [15:0]           regs [4];
   logic [1:0]            a_idx, b_idx, w_idx;
   logic [15:0]           a_val, b_val, alu_r, w_data;
   logic [16:0]           sum_ext;
   logic                  alu_zero, alu_neg, alu_uov, alu_sov;

   // IR bit 7 is not an operand field of any instruction.
   logic unused_ir_bit;
   assign unused_ir_bit = ir[7];

   // Opcode decode from the upper byte of IR; unknown opcodes behave as NOP.
   always_comb begin
      decoded_instruction = I_NOP;
      case (ir[15:8])
         8'h01: decoded_instruction = I_BRANCH;
         8'h02: decoded_instruction = I_BZERO;
         8'h03: decoded_instruction = I_BNEG;
         8'h05: decoded_instruction = I_BOV;
         8'h06: decoded_instruction = I_BNZERO;
         8'h07: decoded_instruction = I_BNNEG;
         8'h08: decoded_instruction = I_BNOV;
         8'h81: decoded_instruction = I_LOAD;
         8'h82: decoded_instruction = I_STORE;
         8'h91: decoded_instruction = I_MOVE;
         8'hA1: decoded_instruction = I_ADD;
         8'hA2: decoded_instruction = I_SUB;
         8'hA3: decoded_instruction = I_AND;
         8'hA4: decoded_instruction = I_OR;
         8'hFF: decoded_instruction = I_HALT;
         default: decoded_instruction = I_NOP;
      endcase
   end

   // Register file port selection. MOVE reads its source on both ports so
   // that an OR of the two ports passes the source value through the ALU.
   always_comb begin
      a_idx = ir[3:2];
      b_idx = ir[1:0];
      w_idx = ir[5:4];
      case (decoded_instruction)
         I_LOAD:  w_idx = ir[6:5];
         I_STORE: b_idx = ir[6:5];
         I_MOVE: begin
            a_idx = ir[1:0];
            w_idx = ir[3:2];
         end
         default: ;
      endcase
   end

   assign a_val    = regs[a_idx];
   assign b_val    = regs[b_idx];
   assign data_out = b_val;
   assign ram_addr = addr_sel ? ir[ADDR_WIDTH-1:0] : pc;

   // ALU. The 17-bit extended sum gives the carry for ADD and, for SUB,
   // bit 16 is set exactly when the unsigned subtraction borrows.
   always_comb begin
      sum_ext = '0;
      alu_r   = '0;
      alu_uov = 1'b0;
      alu_sov = 1'b0;
      case (operation)
         2'b00: alu_r = a_val | b_val;
         2'b01: begin
            sum_ext = {1'b0, a_val} + {1'b0, b_val};
            alu_r   = sum_ext[15:0];
            alu_uov = sum_ext[16];
            alu_sov = (a_val[15] == b_val[15]) && (alu_r[15] != a_val[15]);
         end
         2'b10: begin
            sum_ext = {1'b0, a_val} - {1'b0, b_val};
            alu_r   = sum_ext[15:0];
            alu_uov = sum_ext[16];
            alu_sov = (a_val[15] != b_val[15]) && (alu_r[15] != a_val[15]);
         end
         default: alu_r = a_val & b_val;
      endcase
   end

   assign alu_zero = (alu_r == 16'h0000);
   assign alu_neg  = alu_r[15];
   assign w_data   = c_sel ? alu_r : data_in;

   // PC and IR. Both sample the old IR/PC, so a combined fetch loads the word
   // addressed by the old PC while the PC advances.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
         ir <= '0;
      end else begin
         if (pc_enable)
            pc <= branch ? ir[ADDR_WIDTH-1:0] : pc + ADDR_WIDTH'(1);
         if (ir_enable)
            ir <= data_in;
      end
   end

   // Register file. Writes become visible on the read ports next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++)
            regs[i] <= '0;
      end else if (write_reg_enable) begin
`ifdef KS_R0_ZERO_EN
         if (w_idx != 2'd0)
            regs[w_idx] <= w_data;
`else
         regs[w_idx] <= w_data;
`endif
      end
   end

   // Status flags, loaded only on request so LOAD leaves them untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_op           <= 1'b0;
         neg_op            <= 1'b0;
         unsigned_overflow <= 1'b0;
         signed_overflow   <= 1'b0;
      end else if (flags_reg_enable) begin
         zero_op           <= alu_zero;
         neg_op            <= alu_neg;
         unsigned_overflow <= alu_uov;
         signed_overflow   <= alu_sov;
      end
   end

endmodule
